// File: rtl/botao_debounce.sv
// -----------------------------------------------------------------------------
// botao_debounce
//   Multi-channel push-button conditioner. Each raw button input is brought
//   into the clk domain through a two-flop synchroniser and then debounced:
//   a level change is accepted only after DB_CYCLES consecutive synchronised
//   samples disagree with the current debounced level. Accepted presses
//   (debounced 0->1) produce a one-cycle strobe, and a MODE-selected result
//   is presented on detect.
//
// Parameters
//   N_CH      number of independent channels (1..16)
//   DB_CYCLES consecutive disagreeing samples needed to accept a change (1..255)
//   MODE      detect behaviour: 0 = press strobe, 1 = toggle per press,
//             2 = debounced level
//
// Ports
//   clk     in   1     system clock, rising edge
//   rst_n   in   1     asynchronous active-low reset
//   press   in   N_CH  raw asynchronous button inputs, 1 = pressed
//   detect  out  N_CH  MODE-selected per-channel result
//   pulse   out  N_CH  one-cycle strobe per accepted press
//   stable  out  N_CH  current debounced level
// -----------------------------------------------------------------------------
module botao_debounce #(
  parameter int N_CH      = 4,
  parameter int DB_CYCLES = 4,
  parameter int MODE      = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] press,
  output logic [N_CH-1:0] detect,
  output logic [N_CH-1:0] pulse,
  output logic [N_CH-1:0] stable
);

  // Wide enough to hold DB_CYCLES; the counter itself never goes past
  // DB_CYCLES-1 because reaching that value on a disagreeing sample is the
  // acceptance point.
  localparam int             CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;
  logic [CW-1:0]   cnt      [N_CH];
  logic [CW-1:0]   cnt_nxt  [N_CH];
  logic [N_CH-1:0] stable_nxt;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] detect_nxt;

  // Two-flop synchroniser; nothing downstream looks at press directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= press;
      s2 <= s1;
    end
  end

  // Debounce qualification. Any sample that agrees with the debounced level
  // restarts the count, so a bounce mid-count costs the whole run.
  always_comb begin
    stable_nxt = stable;
    rise       = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = s2[i];
          rise[i]       = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // detect is registered alongside pulse/stable so all three outputs change
  // on the same edge.
  always_comb begin
    detect_nxt = stable_nxt;
    case (MODE)
      0:       detect_nxt = rise;
      1:       detect_nxt = detect ^ rise;
      default: detect_nxt = stable_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
      stable <= '0;
      pulse  <= '0;
      detect <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      stable <= stable_nxt;
      pulse  <= rise;
      detect <= detect_nxt;
    end
  end

endmodule

// File: tb/tb_botao_debounce.sv
module tb_botao_debounce;

  localparam int N = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] press = 4'b0000;

  // Instance 0: MODE 1 DB 4, 1: MODE 0 DB 4, 2: MODE 2 DB 4, 3: MODE 1 DB 1
  logic [3:0] det_o [4];
  logic [3:0] pul_o [4];
  logic [3:0] stb_o [4];
  int db_of   [4] = '{4, 4, 4, 1};
  int mode_of [4] = '{1, 0, 2, 1};

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  botao_debounce #(.N_CH(N), .DB_CYCLES(4), .MODE(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .press(press),
    .detect(det_o[0]), .pulse(pul_o[0]), .stable(stb_o[0]));
  botao_debounce #(.N_CH(N), .DB_CYCLES(4), .MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .press(press),
    .detect(det_o[1]), .pulse(pul_o[1]), .stable(stb_o[1]));
  botao_debounce #(.N_CH(N), .DB_CYCLES(4), .MODE(2)) u_m2 (
    .clk(clk), .rst_n(rst_n), .press(press),
    .detect(det_o[2]), .pulse(pul_o[2]), .stable(stb_o[2]));
  botao_debounce #(.N_CH(N), .DB_CYCLES(1), .MODE(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .press(press),
    .detect(det_o[3]), .pulse(pul_o[3]), .stable(stb_o[3]));

  // Reference model: keep the raw samples of press per edge. The value the
  // debouncer judges at edge t is the raw sample from edge t-2. A change is
  // accepted when the last DB judged samples all disagree with the current
  // debounced level.
  logic [3:0] hist  [8];
  logic [3:0] stb_m [4];
  logic [3:0] pul_m [4];
  logic [3:0] det_m [4];
  logic       acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 8; j++) hist[j] = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        stb_m[k] = 4'b0000;
        pul_m[k] = 4'b0000;
        det_m[k] = 4'b0000;
      end
    end else begin
      for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = press;
      for (int k = 0; k < 4; k++) begin
        for (int ch = 0; ch < N; ch++) begin
          acc = 1'b1;
          for (int j = 2; j < 2 + db_of[k]; j++)
            if (hist[j][ch] == stb_m[k][ch]) acc = 1'b0;
          pul_m[k][ch] = 1'b0;
          if (acc) begin
            stb_m[k][ch] = ~stb_m[k][ch];
            pul_m[k][ch] = stb_m[k][ch];
          end
          if (mode_of[k] == 0)      det_m[k][ch] = pul_m[k][ch];
          else if (mode_of[k] == 1) det_m[k][ch] = det_m[k][ch] ^ pul_m[k][ch];
          else                      det_m[k][ch] = stb_m[k][ch];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (stb_o[k] !== stb_m[k]) begin
          n_fail++;
          $display("FAIL model_stable inst%0d t=%0t got %b exp %b", k, $time, stb_o[k], stb_m[k]);
        end
        n_checks++;
        if (pul_o[k] !== pul_m[k]) begin
          n_fail++;
          $display("FAIL model_pulse inst%0d t=%0t got %b exp %b", k, $time, pul_o[k], pul_m[k]);
        end
        n_checks++;
        if (det_o[k] !== det_m[k]) begin
          n_fail++;
          $display("FAIL model_detect inst%0d t=%0t got %b exp %b", k, $time, det_o[k], det_m[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    press = 4'b1011;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({stb_o[k], pul_o[k], det_o[k]} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_outputs inst%0d got %h exp 000", k, {stb_o[k], pul_o[k], det_o[k]});
      end
    end
    press = 4'b0000;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_clean_press();
    int start, rise_e, rise_d1, pulses, strobes_m0;
    rise_e = -1; rise_d1 = -1; pulses = 0; strobes_m0 = 0;
    press[0] = 1'b1;
    start = edge_cnt;
    repeat (20) begin
      tick();
      if (stb_o[0][0] && rise_e < 0)  rise_e  = edge_cnt - start;
      if (stb_o[3][0] && rise_d1 < 0) rise_d1 = edge_cnt - start;
      if (pul_o[0][0]) pulses++;
      if (det_o[1][0]) strobes_m0++;
    end
    n_checks++;
    if (rise_e !== 6) begin
      n_fail++; $display("FAIL clean_latency got %0d exp 6", rise_e);
    end
    n_checks++;
    if (rise_d1 !== 3) begin
      n_fail++; $display("FAIL db1_latency got %0d exp 3", rise_d1);
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL clean_pulse_count got %0d exp 1", pulses);
    end
    n_checks++;
    if (strobes_m0 !== 1) begin
      n_fail++; $display("FAIL mode0_strobe_count got %0d exp 1", strobes_m0);
    end
    n_checks++;
    if (det_o[0][0] !== 1'b1) begin
      n_fail++; $display("FAIL toggle_on got %b exp 1", det_o[0][0]);
    end
    press[0] = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (det_o[2][0] !== 1'b0) begin
      n_fail++; $display("FAIL mode2_release got %b exp 0", det_o[2][0]);
    end
    n_checks++;
    if (det_o[0][0] !== 1'b1) begin
      n_fail++; $display("FAIL toggle_hold_on_release got %b exp 1", det_o[0][0]);
    end
    press[0] = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (det_o[0][0] !== 1'b0) begin
      n_fail++; $display("FAIL toggle_off got %b exp 0", det_o[0][0]);
    end
    press[0] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_glitch();
    int pulses, stb_seen;
    pulses = 0; stb_seen = 0;
    press[1] = 1'b1;
    repeat (3) tick();
    press[1] = 1'b0;
    repeat (12) begin
      tick();
      if (pul_o[0][1]) pulses++;
      if (stb_o[0][1]) stb_seen++;
    end
    n_checks++;
    if (pulses !== 0 || stb_seen !== 0) begin
      n_fail++; $display("FAIL glitch_reject got pulses=%0d stable_cycles=%0d exp 0/0", pulses, stb_seen);
    end
    n_checks++;
    if (det_o[0][1] !== 1'b0) begin
      n_fail++; $display("FAIL glitch_detect got %b exp 0", det_o[0][1]);
    end
    press[1] = 1'b1;
    repeat (4) tick();
    press[1] = 1'b0;
    repeat (12) begin
      tick();
      if (pul_o[0][1]) pulses++;
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL four_cycle_press got %0d pulses exp 1", pulses);
    end
  endtask

  task automatic test_bounce();
    logic [9:0] pat;
    int start, pulses, pulse_e;
    pat = 10'b1111101101;
    pulses = 0; pulse_e = -1;
    start = edge_cnt;
    for (int i = 0; i < 20; i++) begin
      press[2] = (i < 10) ? pat[i] : 1'b1;
      tick();
      if (pul_o[0][2]) begin
        pulses++;
        pulse_e = edge_cnt - start;
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL bounce_pulse_count got %0d exp 1", pulses);
    end
    n_checks++;
    if (pulse_e !== 11) begin
      n_fail++; $display("FAIL bounce_timing got edge %0d exp 11", pulse_e);
    end
    press[2] = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_simultaneous();
    logic [3:0] first, seen;
    first = 4'b0000; seen = 4'b0000;
    press = 4'b1111;
    repeat (10) begin
      tick();
      if (first == 4'b0000) first = pul_o[0];
    end
    n_checks++;
    if (first !== 4'b1111) begin
      n_fail++; $display("FAIL simultaneous_all got %b exp 1111", first);
    end
    press = 4'b0000;
    repeat (12) tick();
    first = 4'b0000;
    press = 4'b0101;
    repeat (10) begin
      tick();
      if (first == 4'b0000) first = pul_o[0];
      seen = seen | pul_o[0];
    end
    n_checks++;
    if (first !== 4'b0101 || seen !== 4'b0101) begin
      n_fail++; $display("FAIL simultaneous_subset got first=%b any=%b exp 0101", first, seen);
    end
    press = 4'b0000;
    repeat (12) tick();
  endtask

  task automatic test_reset_midcount();
    int start, e_m1, e_d1, pulses;
    e_m1 = -1; e_d1 = -1; pulses = 0;
    press[3] = 1'b1;
    repeat (4) begin
      tick();
      if (pul_o[0][3]) pulses++;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({stb_o[k], pul_o[k], det_o[k]} !== 12'h000) begin
        n_fail++;
        $display("FAIL async_reset inst%0d got %h exp 000", k, {stb_o[k], pul_o[k], det_o[k]});
      end
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    start = edge_cnt;
    repeat (10) begin
      tick();
      if (pul_o[0][3]) begin
        pulses++;
        if (e_m1 < 0) e_m1 = edge_cnt - start;
      end
      if (pul_o[3][3] && e_d1 < 0) e_d1 = edge_cnt - start;
    end
    n_checks++;
    if (e_m1 !== 6) begin
      n_fail++; $display("FAIL reset_held_press got edge %0d exp 6", e_m1);
    end
    n_checks++;
    if (e_d1 !== 3) begin
      n_fail++; $display("FAIL reset_held_press_db1 got edge %0d exp 3", e_d1);
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL aborted_event_pulses got %0d exp 1", pulses);
    end
    press[3] = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_random();
    int hold [4];
    int dut_pulses, mdl_pulses;
    dut_pulses = 0; mdl_pulses = 0;
    for (int ch = 0; ch < 4; ch++) hold[ch] = 0;
    repeat (1500) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (hold[ch] == 0) begin
          press[ch] = 1'($urandom_range(0, 1));
          hold[ch]  = $urandom_range(1, 7);
        end
        hold[ch]--;
      end
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
      for (int ch = 0; ch < 4; ch++) begin
        dut_pulses += int'(pul_o[0][ch]);
        mdl_pulses += int'(pul_m[0][ch]);
      end
    end
    rst_n = 1'b1;
    press = 4'b0000;
    repeat (12) tick();
    n_checks++;
    if (dut_pulses !== mdl_pulses) begin
      n_fail++; $display("FAIL random_pulse_total got %0d exp %0d", dut_pulses, mdl_pulses);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_midcount();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
